// File: rtl/accumulate_if.sv
// rtl/accumulate_if.sv - sample input and frame-total output streams of the accumulator
interface accumulate_if #(
  parameter int W = 9,
  parameter int N = 4
);
  localparam int OW = W + $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/accumulate.sv
// rtl/accumulate.sv - sums N accepted signed samples into one registered frame total
module accumulate #(
  parameter int W = 9,
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  accumulate_if.slave bus
);
  localparam int OW = W + $clog2(N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state_q, state_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_data_q, out_data_d;
  logic signed [OW-1:0] sum;
  logic                 accept;

  assign bus.in_ready  = (state_q == ACC) && !clr && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = acc_q + OW'(signed'(bus.in_data));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ACC: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST) begin
            out_data_d  = sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // clr is deliberately ignored here so a pending total is never dropped
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_accumulate.sv
// tb/tb_accumulate.sv - scoreboard bench for accumulate: directed test-plan frames plus random traffic
module tb_accumulate;
  localparam int W  = 9;
  localparam int N  = 4;
  localparam int OW = W + $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic clr;

  accumulate_if #(.W(W), .N(N)) bus ();

  accumulate #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic signed [OW-1:0] exp_q[$];
  int                   frame[$];
  bit                   hold = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes an output transfer
  bit                   prev_wait = 1'b0;
  logic signed [OW-1:0] prev_data;
  always @(negedge clk) begin
    chk("out_valid_vs_model", longint'(bus.out_valid), longint'(hold));
    if (prev_wait) begin
      chk("hold_stable_data", longint'(bus.out_data), longint'(prev_data));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", longint'(bus.out_data), 0);
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=none", bus.out_data);
      end else begin
        chk("out_data", longint'(bus.out_data), longint'(exp_q.pop_front()));
      end
    end
    prev_wait = bus.out_valid && !bus.out_ready && !rst;
    prev_data = bus.out_data;
  end

  // One clock cycle of stimulus; model advances with the edge that consumes it
  task automatic cycle(input bit v, input int d, input bit ordy, input bit c, input bit r);
    int s;
    bus.in_valid  = v;
    bus.in_data   = W'(d);
    bus.out_ready = ordy;
    clr           = c;
    rst           = r;
    #2;
    chk("in_ready", longint'(bus.in_ready), longint'(!hold && !c && !r));
    @(posedge clk);
    if (r) begin
      if (hold && !ordy) void'(exp_q.pop_back());
      frame.delete();
      hold = 1'b0;
    end else if (hold) begin
      if (ordy) hold = 1'b0;
    end else if (c) begin
      frame.delete();
    end else if (v) begin
      frame.push_back(d);
      if (frame.size() == N) begin
        s = 0;
        foreach (frame[i]) s += frame[i];
        exp_q.push_back(OW'(s));
        frame.delete();
        hold = 1'b1;
      end
    end
    #1;
  endtask

  task automatic beats(input int a, input int b, input int c, input int d, input bit ordy);
    cycle(1, a, ordy, 0, 0);
    cycle(1, b, ordy, 0, 0);
    cycle(1, c, ordy, 0, 0);
    cycle(1, d, ordy, 0, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
    rst           = 1'b1;

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_out_data", longint'(bus.out_data), 0);

    // full-scale positive and negative frames
    beats(255, 255, 255, 255, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    beats(-256, -256, -256, -256, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // backpressure: six HOLD cycles with beats offered but refused
    beats(100, -50, 7, -3, 0);
    for (int i = 0; i < 5; i++) cycle(1, 77, 0, 0, 0);
    chk("bp_held_value", longint'(bus.out_data), 54);
    cycle(1, 77, 1, 0, 0);
    beats(1, 1, 1, 1, 1);
    cycle(0, 0, 1, 0, 0);

    // bubbles, clr in ACC, clr during HOLD
    cycle(1, 10, 1, 0, 0);
    cycle(1, 20, 1, 0, 0);
    cycle(1, 99, 1, 1, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("clr_hold_value", longint'(bus.out_data), 10);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);

    // reset mid-frame, then reset during HOLD
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 1);
    beats(1, 1, 1, 1, 1);
    cycle(0, 0, 1, 0, 0);
    beats(5, 5, 5, 5, 0);
    cycle(0, 0, 0, 0, 1);
    chk("rst_hold_out_valid", longint'(bus.out_valid), 0);
    chk("rst_hold_out_data", longint'(bus.out_data), 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(99) < 70,
            int'($urandom_range(511)) - 256,
            $urandom_range(99) < 60,
            $urandom_range(99) < 5,
            $urandom_range(199) < 3);
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accumulate.md
# accumulate

Frame accumulator that sits directly downstream of the signed two-operand adder stage. It consumes the adder's sum as a valid/ready stream and adds exactly N consecutive accepted samples into one signed total. It presents that total on a registered output with its own valid/ready handshake and holds it until the consumer takes it. Widths are chosen so the total never overflows.

## Interface
- W, default 9, input sample width in bits, signed (matches an 8+8 adder output).
- N, default 4, samples per frame; legal N >= 1.
- OW (derived, not overridable), W + $clog2(N), output width; 11 for defaults.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous flush of a partial frame.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  W  signed sample.
- out_valid  out  1  out_data holds a completed frame total.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  OW  signed frame total, registered.

## Operation
- Two states:
  - ACC: accepting samples.
  - HOLD: a result is waiting.
- Internal registers:
  - acc: OW bits, signed.
  - cnt: 0..N-1.
- A beat is accepted when in_valid && in_ready.
- in_ready = (state == ACC) && !clr && !rst. It is combinational and independent of in_valid.
- Each accepted beat sign-extends in_data to OW bits and adds it into acc. cnt increments on each accepted beat. Cycles with in_valid low leave acc and cnt unchanged.
- Accepted beat with cnt == N-1:
  - out_data <= acc + sext(in_data)
  - acc <= 0, cnt <= 0
  - out_valid <= 1, state <= HOLD
- N = 1: every accepted beat is a complete frame.
- HOLD:
  - out_valid = 1, in_ready = 0.
  - out_data stays stable while out_ready is low.
  - out_ready high completes the transfer. Next cycle: out_valid = 0, state = ACC.
- clr in ACC: acc <= 0 and cnt <= 0. The in_data beat presented that cycle is not accepted.
- clr in HOLD: no effect. The pending result is never dropped by clr.
- Arithmetic is two's complement with no saturation. The range N*(-2^(W-1)) .. N*(2^(W-1)-1) fits in OW bits by construction.
- rst overrides clr and every handshake.

## Timing
- Reset values, all forced on any clock edge with rst high, including mid-frame and in HOLD:
  - state = ACC, acc = 0, cnt = 0
  - out_valid = 0, out_data = 0
  - in_ready = 0 while rst is high; 1 on the first cycle after rst deasserts (clr low).
- Latency: out_valid rises one cycle after the edge that accepts the Nth beat.
- Best-case throughput is one frame per N+1 cycles: N accept cycles plus one HOLD cycle with out_ready high.
- in_ready is low in the HOLD cycle. The first beat of the next frame is accepted in the cycle after the output transfer.
- Output transfer and reset in the same cycle: reset wins and the result is lost.
- out_valid never drops without out_ready, except on rst.

## Test plan
All scenarios use W=9, N=4, OW=11.
- Full-scale positive: 255,255,255,255 back-to-back with out_ready=1 -> out_data=1020, out_valid high exactly 1 cycle; in_ready low in that cycle and high the next.
- Full-scale negative: -256 x4 -> out_data = -1024 (11'h400), no wrap.
- Backpressure: frame 100,-50,7,-3 with out_ready low for 5 cycles -> out_data=54 stable for all 6 HOLD cycles; in_ready=0 throughout; in_valid beats offered then are not accepted. Next frame 1,1,1,1 -> 4.
- Bubbles and clr:
  - 10,20 accepted, then clr with in_valid=1, in_data=99 -> 99 is dropped.
  - Then 1,2,3,4 with idle cycles between beats -> out_data=10.
  - clr asserted during HOLD -> result still delivered.
- Reset mid-operation:
  - rst after 3 accepted beats, then frame 1,1,1,1 -> out_data=4.
  - rst during HOLD -> out_valid=0 and out_data=0 the next cycle.
